// File: rtl/serial_subtractor_if.sv
// Purpose : start/result bundle between a requester and the bit-serial subtractor.
// Ports   : START, A, B from the requester; BUSY, DONE, D, BO, OV, ZERO from the subtractor.
// Flow    : START is a request, not a credit. It is ignored while BUSY is high.
interface serial_subtractor_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  START;
  logic [DATA_WIDTH-1:0] A;
  logic [DATA_WIDTH-1:0] B;
  logic                  BUSY;
  logic                  DONE;
  logic [DATA_WIDTH-1:0] D;
  logic                  BO;
  logic                  OV;
  logic                  ZERO;

  // Requester side.
  modport master (
    output START, A, B,
    input  BUSY, DONE, D, BO, OV, ZERO
  );

  // Subtractor side.
  modport slave (
    input  START, A, B,
    output BUSY, DONE, D, BO, OV, ZERO
  );
endinterface

// File: rtl/serial_subtractor.sv
// Purpose : bit-serial D = A - B. One bit per cycle, LSB first, through a registered borrow.
// Latency : START in cycle 0 gives BUSY in cycles 1..DATA_WIDTH and a DONE pulse in cycle DATA_WIDTH+1.
// Backpr. : START is ignored while BUSY is high. It is accepted in IDLE or DONE, so held START chains operations.
// Ports   : CLK and RST (synchronous, active-high) are scalar ports. All other signals are on the bus (slave modport).
module serial_subtractor #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                CLK,
  input  logic                RST,
  serial_subtractor_if.slave  bus
);

  localparam int CW = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                state_q;
  logic [DATA_WIDTH-1:0] a_q;
  logic [DATA_WIDTH-1:0] b_q;
  // Holds bits 0..DATA_WIDTH-2 of the difference. The final bit is
  // concatenated on the last RUN cycle, so no register bit is dead.
  logic [DATA_WIDTH-2:0] res_q;
  logic                  brw_q;
  logic [CW-1:0]         cnt_q;
  logic                  a_msb_q;
  logic                  b_msb_q;
  logic                  busy_q;
  logic                  done_q;
  logic [DATA_WIDTH-1:0] d_q;
  logic                  bo_q;
  logic                  ov_q;
  logic                  zero_q;

  logic                  d_bit;
  logic                  brw_d;
  logic [DATA_WIDTH-1:0] res_d;
  logic                  last_bit;
  logic                  ov_d;

  // One full-subtractor cell operating on the operand LSBs.
  always_comb begin
    d_bit    = a_q[0] ^ b_q[0] ^ brw_q;
    brw_d    = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & brw_q);
    res_d    = {d_bit, res_q};
    last_bit = (cnt_q == CW'(DATA_WIDTH - 1));
    // Signed overflow only occurs when the operand signs differ.
    ov_d     = (a_msb_q != b_msb_q) && (res_d[DATA_WIDTH-1] != a_msb_q);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      brw_q   <= 1'b0;
      cnt_q   <= '0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      d_q     <= '0;
      bo_q    <= 1'b0;
      ov_q    <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          done_q <= 1'b0;
          if (bus.START) begin
            a_q     <= bus.A;
            b_q     <= bus.B;
            a_msb_q <= bus.A[DATA_WIDTH-1];
            b_msb_q <= bus.B[DATA_WIDTH-1];
            brw_q   <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end else begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end

        S_RUN: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          brw_q <= brw_d;
          res_q <= res_d[DATA_WIDTH-1:1];
          cnt_q <= cnt_q + 1'b1;
          if (last_bit) begin
            // The result registers change only here, on entry to DONE.
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            d_q     <= res_d;
            bo_q    <= brw_d;
            ov_q    <= ov_d;
            zero_q  <= (res_d == '0);
            state_q <= S_DONE;
          end
        end

        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.BUSY = busy_q;
  assign bus.DONE = done_q;
  assign bus.D    = d_q;
  assign bus.BO   = bo_q;
  assign bus.OV   = ov_q;
  assign bus.ZERO = zero_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Purpose : directed bench for serial_subtractor with DATA_WIDTH = 8.
// Ports   : drives CLK, RST and the master side of serial_subtractor_if.
// Timing  : inputs change and outputs are sampled 1 ns after each rising edge.
module tb_serial_subtractor;

  localparam int W = 8;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   nchecks = 0;
  int   nerrors = 0;

  serial_subtractor_if #(.DATA_WIDTH(W)) bus ();

  serial_subtractor #(.DATA_WIDTH(W)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  always #5 CLK = ~CLK;

  // Pulses START for one cycle, then waits (bounded) for DONE.
  // lat is the cycle index of DONE relative to the START cycle, or -1 if DONE never arrives.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] d, output logic bo, output logic ov,
                       output logic zero, output int lat);
    @(posedge CLK); #1;
    bus.START = 1'b1; bus.A = a; bus.B = b;
    lat = -1; d = 'x; bo = 1'bx; ov = 1'bx; zero = 1'bx;
    for (int c = 1; c <= 20 && lat < 0; c++) begin
      @(posedge CLK); #1;
      if (c == 1) bus.START = 1'b0;
      if (bus.DONE) begin
        lat = c; d = bus.D; bo = bus.BO; ov = bus.OV; zero = bus.ZERO;
      end
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; bus.START = 1'b0; bus.A = '0; bus.B = '0;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    nchecks++;
    if ({bus.BUSY, bus.DONE, bus.BO, bus.OV, bus.ZERO} !== 5'b0 || bus.D !== 8'h00) begin
      nerrors++;
      $display("FAIL reset: busy=%b done=%b d=%h bo=%b ov=%b zero=%b, required all 0",
               bus.BUSY, bus.DONE, bus.D, bus.BO, bus.OV, bus.ZERO);
    end
  endtask

  task automatic test_basic();
    int busy_cnt = 0;
    int done_at = -1;
    int overlap = 0;
    @(posedge CLK); #1;
    bus.START = 1'b1; bus.A = 8'h05; bus.B = 8'h03;
    for (int c = 1; c <= 12; c++) begin
      @(posedge CLK); #1;
      bus.START = 1'b0;
      if (bus.BUSY && c <= 8) busy_cnt++;
      if (bus.BUSY && bus.DONE) overlap++;
      if (bus.DONE && done_at < 0) done_at = c;
      if (c == 9) begin
        nchecks++;
        if (bus.D !== 8'h02 || bus.BO !== 1'b0 || bus.OV !== 1'b0 || bus.ZERO !== 1'b0) begin
          nerrors++;
          $display("FAIL basic_result: d=%h bo=%b ov=%b zero=%b, required 02 0 0 0",
                   bus.D, bus.BO, bus.OV, bus.ZERO);
        end
      end
    end
    nchecks++;
    if (busy_cnt != 8) begin
      nerrors++; $display("FAIL basic_busy: busy cycles=%0d, required 8", busy_cnt);
    end
    nchecks++;
    if (done_at != 9) begin
      nerrors++; $display("FAIL basic_done_cycle: done at %0d, required 9", done_at);
    end
    nchecks++;
    if (overlap != 0) begin
      nerrors++; $display("FAIL basic_overlap: busy&done cycles=%0d, required 0", overlap);
    end
  endtask

  task automatic test_edges();
    logic [W-1:0] va [3] = '{8'h03, 8'h80, 8'h7F};
    logic [W-1:0] vb [3] = '{8'h05, 8'h01, 8'hFF};
    logic [W-1:0] ed [3] = '{8'hFE, 8'h7F, 8'h80};
    logic         ebo[3] = '{1'b1, 1'b0, 1'b1};
    logic         eov[3] = '{1'b0, 1'b1, 1'b1};
    logic [W-1:0] d;
    logic bo, ov, z;
    int lat;
    for (int i = 0; i < 3; i++) begin
      do_op(va[i], vb[i], d, bo, ov, z, lat);
      nchecks++;
      if (lat != 9 || d !== ed[i] || bo !== ebo[i] || ov !== eov[i] || z !== 1'b0) begin
        nerrors++;
        $display("FAIL edge_%0d: lat=%0d d=%h bo=%b ov=%b zero=%b, required 9 %h %b %b 0",
                 i, lat, d, bo, ov, z, ed[i], ebo[i], eov[i]);
      end
    end
  endtask

  task automatic test_zero();
    logic [W-1:0] d;
    logic bo, ov, z;
    int lat;
    do_op(8'hA5, 8'hA5, d, bo, ov, z, lat);
    nchecks++;
    if (lat != 9 || d !== 8'h00 || z !== 1'b1 || bo !== 1'b0 || ov !== 1'b0) begin
      nerrors++;
      $display("FAIL zero_equal: lat=%0d d=%h zero=%b bo=%b ov=%b, required 9 00 1 0 0", lat, d, z, bo, ov);
    end
    do_op(8'h10, 8'h00, d, bo, ov, z, lat);
    nchecks++;
    if (lat != 9 || d !== 8'h10 || z !== 1'b0 || bo !== 1'b0 || ov !== 1'b0) begin
      nerrors++;
      $display("FAIL zero_bzero: lat=%0d d=%h zero=%b bo=%b ov=%b, required 9 10 0 0 0", lat, d, z, bo, ov);
    end
    // The result holds through IDLE.
    repeat (3) @(posedge CLK);
    #1;
    nchecks++;
    if (bus.D !== 8'h10 || bus.DONE !== 1'b0) begin
      nerrors++; $display("FAIL idle_hold: d=%h done=%b, required 10 0", bus.D, bus.DONE);
    end
  endtask

  task automatic test_start_ignored();
    int ndone = 0;
    int done_at = -1;
    logic [W-1:0] d_mid = 'x;
    logic [W-1:0] d_fin = 'x;
    @(posedge CLK); #1;
    bus.START = 1'b1; bus.A = 8'h20; bus.B = 8'h07;
    for (int c = 1; c <= 20; c++) begin
      @(posedge CLK); #1;
      bus.START = (c == 3);
      if (c == 3) begin bus.A = 8'hFF; bus.B = 8'h01; end
      if (c == 5) d_mid = bus.D;
      if (bus.DONE) begin
        ndone++;
        if (done_at < 0) begin done_at = c; d_fin = bus.D; end
      end
    end
    bus.START = 1'b0;
    nchecks++;
    if (d_mid !== 8'h10) begin
      nerrors++; $display("FAIL run_hold: d during run=%h, required 10", d_mid);
    end
    nchecks++;
    if (ndone != 1 || done_at != 9 || d_fin !== 8'h19) begin
      nerrors++;
      $display("FAIL start_ignored: dones=%0d at=%0d d=%h, required 1 9 19", ndone, done_at, d_fin);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] va [3] = '{8'h05, 8'h00, 8'h7F};
    logic [W-1:0] vb [3] = '{8'h03, 8'h01, 8'h80};
    logic [W-1:0] ed [3] = '{8'h02, 8'hFF, 8'hFF};
    logic         ebo[3] = '{1'b0, 1'b1, 1'b1};
    logic         eov[3] = '{1'b0, 1'b0, 1'b1};
    int n = 0;
    int prev = -1;
    int overlap = 0;
    @(posedge CLK); #1;
    bus.START = 1'b1; bus.A = va[0]; bus.B = vb[0];
    for (int c = 1; c <= 60 && n < 3; c++) begin
      @(posedge CLK); #1;
      if (bus.BUSY && bus.DONE) overlap++;
      if (bus.DONE) begin
        nchecks++;
        if (bus.D !== ed[n] || bus.BO !== ebo[n] || bus.OV !== eov[n] || (prev >= 0 && c - prev != 9)) begin
          nerrors++;
          $display("FAIL b2b_%0d: d=%h bo=%b ov=%b gap=%0d, required %h %b %b 9",
                   n, bus.D, bus.BO, bus.OV, c - prev, ed[n], ebo[n], eov[n]);
        end
        prev = c;
        n++;
        if (n < 3) begin bus.A = va[n]; bus.B = vb[n]; end
        else bus.START = 1'b0;
      end
    end
    bus.START = 1'b0;
    nchecks++;
    if (n != 3 || overlap != 0) begin
      nerrors++; $display("FAIL b2b_count: dones=%0d overlap=%0d, required 3 0", n, overlap);
    end
  endtask

  task automatic test_reset_abort();
    int ndone = 0;
    logic [W-1:0] d;
    logic bo, ov, z;
    int lat;
    @(posedge CLK); #1;
    bus.START = 1'b1; bus.A = 8'h33; bus.B = 8'h11;
    for (int c = 1; c <= 4; c++) begin
      @(posedge CLK); #1;
      bus.START = 1'b0;
    end
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    nchecks++;
    if ({bus.BUSY, bus.DONE, bus.BO, bus.OV, bus.ZERO} !== 5'b0 || bus.D !== 8'h00) begin
      nerrors++;
      $display("FAIL abort_clear: busy=%b done=%b d=%h bo=%b ov=%b zero=%b, required all 0",
               bus.BUSY, bus.DONE, bus.D, bus.BO, bus.OV, bus.ZERO);
    end
    for (int c = 0; c < 12; c++) begin
      if (bus.DONE || bus.BUSY) ndone++;
      @(posedge CLK); #1;
    end
    nchecks++;
    if (ndone != 0) begin
      nerrors++; $display("FAIL abort_quiet: busy/done cycles=%0d, required 0", ndone);
    end
    do_op(8'h09, 8'h04, d, bo, ov, z, lat);
    nchecks++;
    if (lat != 9 || d !== 8'h05 || bo !== 1'b0 || ov !== 1'b0 || z !== 1'b0) begin
      nerrors++;
      $display("FAIL abort_restart: lat=%0d d=%h bo=%b ov=%b zero=%b, required 9 05 0 0 0", lat, d, bo, ov, z);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_edges();
    test_zero();
    test_start_ignored();
    test_back_to_back();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
